// File: rtl/potato_timer_ctrl.sv
// potato_timer_ctrl: countdown sequencer for the potato-game display.
// Owns the four BCD time digits, the edit cursor and the highlight code,
// and runs the SET / RUN / PAUSE / DONE flow driven by debounced button pulses.
// Time is kept packed as {minute2, minute1, second2, second1}, one nibble each.
module potato_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [4:0] select,
  output logic [4:0] second1,
  output logic [4:0] second2,
  output logic [4:0] minute1,
  output logic [4:0] minute2,
  output logic       running,
  output logic       expired
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] BLINK_LAST = PW'((TICKS_PER_SEC / 2) - 1);
  localparam logic [15:0]   TIME_RESET = 16'h0100;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Registered state
  state_t        state_r;
  logic [2:0]    cursor_r;
  logic [15:0]   time_r;
  logic [15:0]   preset_r;
  logic [PW-1:0] prescaler_r;
  logic [PW-1:0] blink_cnt_r;
  logic          blink_phase_r;

  // Next-state values
  state_t        state_s;
  logic [2:0]    cursor_s;
  logic [15:0]   time_s;
  logic [15:0]   preset_s;
  logic [PW-1:0] prescaler_s;
  logic [PW-1:0] blink_cnt_s;
  logic          blink_phase_s;
  logic [4:0]    select_s;
  logic          running_s;
  logic          expired_s;

  // Arbitrated button actions and derived conditions
  logic          act_start_s;
  logic          act_left_s;
  logic          act_right_s;
  logic          act_up_s;
  logic          act_down_s;
  logic          time_zero_s;
  logic          tick_last_s;
  logic [15:0]   time_dec_s;
  logic          dec_zero_s;

  // Increment a digit modulo (max+1); out-of-range inputs fold back to zero.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    logic [3:0] r;
    if (d >= max) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  // Decrement a digit modulo (max+1); zero (or out-of-range) wraps to max.
  function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] max);
    logic [3:0] r;
    if ((d == 4'd0) || (d > max)) begin
      r = max;
    end else begin
      r = d - 4'd1;
    end
    return r;
  endfunction

  // Subtract one second from a packed mm:ss BCD value with the full borrow chain.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] m1;
    logic [3:0] m2;
    s1 = t[3:0];
    s2 = t[7:4];
    m1 = t[11:8];
    m2 = t[15:12];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s2 != 4'd0) begin
        s2 = s2 - 4'd1;
      end else begin
        s2 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1 = 4'd9;
          m2 = digit_dec(m2, 4'd9);
        end
      end
    end
    return {m2, m1, s2, s1};
  endfunction

  // Only one button acts per cycle: start > left > right > up > down.
  assign act_start_s = btn_start;
  assign act_left_s  = btn_left  & ~btn_start;
  assign act_right_s = btn_right & ~btn_start & ~btn_left;
  assign act_up_s    = btn_up    & ~btn_start & ~btn_left & ~btn_right;
  assign act_down_s  = btn_down  & ~btn_start & ~btn_left & ~btn_right & ~btn_up;

  assign time_zero_s = (time_r == 16'd0);
  assign tick_last_s = (prescaler_r == TICK_LAST);
  assign time_dec_s  = time_dec(time_r);
  assign dec_zero_s  = (time_dec_s == 16'd0);

  // Digit outputs come straight from the time register; upper bits are zero.
  assign second1 = {1'b0, time_r[3:0]};
  assign second2 = {1'b0, time_r[7:4]};
  assign minute1 = {1'b0, time_r[11:8]};
  assign minute2 = {1'b0, time_r[15:12]};

  // State register plus datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_SET;
      cursor_r      <= 3'd0;
      time_r        <= TIME_RESET;
      preset_r      <= TIME_RESET;
      prescaler_r   <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      select        <= 5'd0;
      running       <= 1'b0;
      expired       <= 1'b0;
    end else begin
      state_r       <= state_s;
      cursor_r      <= cursor_s;
      time_r        <= time_s;
      preset_r      <= preset_s;
      prescaler_r   <= prescaler_s;
      blink_cnt_r   <= blink_cnt_s;
      blink_phase_r <= blink_phase_s;
      select        <= select_s;
      running       <= running_s;
      expired       <= expired_s;
    end
  end

  // Next-state selection for the SET / RUN / PAUSE / DONE flow.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_SET: begin
        if (act_start_s && !time_zero_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SET;
        end
      end
      ST_RUN: begin
        if (act_start_s) begin
          state_s = ST_PAUSE;
        end else if (tick_last_s && dec_zero_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (act_start_s) begin
          state_s = ST_RUN;
        end else if (act_left_s || act_right_s) begin
          state_s = ST_SET;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (act_start_s) begin
          state_s = ST_SET;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_SET;
    endcase
  end

  // Datapath updates: editing, presets, prescaler, countdown and blink timing.
  always_comb begin
    cursor_s      = cursor_r;
    time_s        = time_r;
    preset_s      = preset_r;
    prescaler_s   = prescaler_r;
    blink_cnt_s   = '0;
    blink_phase_s = 1'b0;
    case (state_r)
      ST_SET: begin
        if (act_start_s) begin
          if (!time_zero_s) begin
            preset_s    = time_r;
            prescaler_s = '0;
          end else begin
            preset_s    = preset_r;
          end
        end else if (act_left_s) begin
          cursor_s = (cursor_r == 3'd0) ? 3'd4 : (cursor_r - 3'd1);
        end else if (act_right_s) begin
          cursor_s = (cursor_r >= 3'd4) ? 3'd0 : (cursor_r + 3'd1);
        end else if (act_up_s) begin
          case (cursor_r)
            3'd0:    time_s[3:0]   = digit_inc(time_r[3:0],   4'd9);
            3'd1:    time_s[7:4]   = digit_inc(time_r[7:4],   4'd5);
            3'd2:    time_s[11:8]  = digit_inc(time_r[11:8],  4'd9);
            3'd3:    time_s[15:12] = digit_inc(time_r[15:12], 4'd9);
            default: time_s        = time_r;
          endcase
        end else if (act_down_s) begin
          case (cursor_r)
            3'd0:    time_s[3:0]   = digit_dec(time_r[3:0],   4'd9);
            3'd1:    time_s[7:4]   = digit_dec(time_r[7:4],   4'd5);
            3'd2:    time_s[11:8]  = digit_dec(time_r[11:8],  4'd9);
            3'd3:    time_s[15:12] = digit_dec(time_r[15:12], 4'd9);
            default: time_s        = time_r;
          endcase
        end else begin
          time_s = time_r;
        end
      end
      ST_RUN: begin
        if (act_start_s) begin
          // Pausing on a terminal tick swallows that second's decrement.
          if (tick_last_s) begin
            prescaler_s = '0;
          end else begin
            prescaler_s = prescaler_r;
          end
        end else if (tick_last_s) begin
          prescaler_s = '0;
          time_s      = time_dec_s;
        end else begin
          prescaler_s = prescaler_r + PW'(1);
        end
      end
      ST_PAUSE: begin
        prescaler_s = prescaler_r;
      end
      ST_DONE: begin
        if (act_start_s) begin
          time_s = preset_r;
        end else if (blink_cnt_r >= BLINK_LAST) begin
          blink_cnt_s   = '0;
          blink_phase_s = ~blink_phase_r;
        end else begin
          blink_cnt_s   = blink_cnt_r + PW'(1);
          blink_phase_s = blink_phase_r;
        end
      end
      default: begin
        cursor_s = 3'd0;
        time_s   = TIME_RESET;
      end
    endcase
  end

  // Output decode from the next state so outputs land on the transition edge.
  always_comb begin
    select_s  = 5'd5;
    running_s = 1'b0;
    expired_s = 1'b0;
    case (state_s)
      ST_SET:   select_s = {2'b00, cursor_s};
      ST_RUN: begin
        select_s  = 5'd4;
        running_s = 1'b1;
      end
      ST_PAUSE: select_s = 5'd5;
      ST_DONE: begin
        select_s  = blink_phase_s ? 5'd5 : 5'd4;
        expired_s = 1'b1;
      end
      default:  select_s = 5'd5;
    endcase
  end

endmodule
